// File: rtl/regfile_mp.sv
// Parametrised integer register file: N combinational read ports, one write port,
// optional hardwired x0 and write-to-read bypass, plus a one-entry-per-cycle clear sweep.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iWE,
  input  logic [AW-1:0]       iRD,
  input  logic [XLEN-1:0]     iREG_IN,
  input  logic [NRD*AW-1:0]   iRS,
  output logic [NRD*XLEN-1:0] oREG_OUT,
  input  logic                iCLR,
  output logic                oBUSY,
  output logic                oState
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t          state, stateNext;
  logic [AW-1:0]   ptr, ptrNext;
  logic            busyNext;
  logic            lastEntry;
  logic            wrEn;
  logic [XLEN-1:0] regs [NREGS];

  // ptr never advances past NREGS-1, so an AW-bit pointer with an AW-bit terminal compare suffices.
  assign lastEntry = (ptr == AW'(NREGS - 1));
  assign wrEn      = (state == IDLE) && iWE && !(ZERO_REG && (iRD == '0));
  assign oState    = state;

  always_comb begin
    stateNext = state;
    ptrNext   = ptr;
    busyNext  = oBUSY;
    if (iRST) begin
      stateNext = CLEAR;
      ptrNext   = '0;
      busyNext  = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (iCLR) begin
            stateNext = CLEAR;
            ptrNext   = '0;
            busyNext  = 1'b1;
          end
        end
        CLEAR: begin
          if (lastEntry) begin
            stateNext = IDLE;
            ptrNext   = '0;
            busyNext  = 1'b0;
          end else begin
            ptrNext = ptr + AW'(1);
          end
        end
        default: begin
          stateNext = CLEAR;
          ptrNext   = '0;
          busyNext  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    state <= stateNext;
    ptr   <= ptrNext;
    oBUSY <= busyNext;
  end

  // Storage is deliberately left untouched on the reset edge; the sweep zeroes it afterwards.
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      if (state == CLEAR) begin
        regs[ptr] <= '0;
      end else if (wrEn) begin
        regs[iRD] <= iREG_IN;
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : gRead
    logic [AW-1:0]   rs;
    logic [XLEN-1:0] rdData;

    assign rs = iRS[k*AW +: AW];

    always_comb begin
      rdData = regs[rs];
      if (oBUSY || (ZERO_REG && (rs == '0))) begin
        rdData = '0;
      end else if (BYPASS && wrEn && (iRD == rs)) begin
        rdData = iREG_IN;
      end
    end

    assign oREG_OUT[k*XLEN +: XLEN] = rdData;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default build (x0 hardwired, bypass on) and a small build
// (16-bit, 8 entries, no x0, no bypass) driven side by side against a behavioural model.
module tb_regfile_mp;

  localparam int XA = 32, NA = 32, AWA = 5;
  localparam int XB = 16, NB = 8,  AWB = 3;

  logic           clk, rst, clr;
  logic           weA, weB;
  logic [AWA-1:0] rdA;
  logic [AWB-1:0] rdB;
  logic [XA-1:0]  dinA;
  logic [XB-1:0]  dinB;
  logic [2*AWA-1:0] rsA;
  logic [2*AWB-1:0] rsB;
  logic [2*XA-1:0]  outA;
  logic [2*XB-1:0]  outB;
  logic busyOutA, busyOutB, stateA, stateB;

  regfile_mp #(.XLEN(XA), .NREGS(NA), .NRD(2), .ZERO_REG(1'b1), .BYPASS(1'b1)) dutA (
    .iCLK(clk), .iRST(rst), .iWE(weA), .iRD(rdA), .iREG_IN(dinA), .iRS(rsA),
    .oREG_OUT(outA), .iCLR(clr), .oBUSY(busyOutA), .oState(stateA)
  );

  regfile_mp #(.XLEN(XB), .NREGS(NB), .NRD(2), .ZERO_REG(1'b0), .BYPASS(1'b0)) dutB (
    .iCLK(clk), .iRST(rst), .iWE(weB), .iRD(rdB), .iREG_IN(dinB), .iRS(rsB),
    .oREG_OUT(outB), .iCLR(clr), .oBUSY(busyOutB), .oState(stateB)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: contents plus a count of sweep edges still to go
  logic [XA-1:0] memA [NA];
  logic [XB-1:0] memB [NB];
  bit busyA, busyB;
  int leftA, leftB;

  int nTests = 0;
  int nFail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [XA-1:0] expA(input int k);
    logic [AWA-1:0] rs;
    rs = rsA[k*AWA +: AWA];
    if (busyA || rs == 0) return '0;
    if (weA && rdA == rs) return dinA;
    return memA[rs];
  endfunction

  function automatic logic [XB-1:0] expB(input int k);
    logic [AWB-1:0] rs;
    rs = rsB[k*AWB +: AWB];
    if (busyB) return '0;
    return memB[rs];
  endfunction

  task automatic modelEdge();
    if (rst) begin
      busyA = 1; leftA = NA;
      busyB = 1; leftB = NB;
      return;
    end
    if (busyA) begin
      leftA--;
      if (leftA == 0) begin
        busyA = 0;
        for (int i = 0; i < NA; i++) memA[i] = '0;
      end
    end else begin
      if (weA && rdA != 0) memA[rdA] = dinA;
      if (clr) begin busyA = 1; leftA = NA; end
    end
    if (busyB) begin
      leftB--;
      if (leftB == 0) begin
        busyB = 0;
        for (int i = 0; i < NB; i++) memB[i] = '0;
      end
    end else begin
      if (weB) memB[rdB] = dinB;
      if (clr) begin busyB = 1; leftB = NB; end
    end
  endtask

  task automatic checkOutputs();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("readA%0d", k), 64'(outA[k*XA +: XA]), 64'(expA(k)));
      check($sformatf("readB%0d", k), 64'(outB[k*XB +: XB]), 64'(expB(k)));
    end
    check("busyA", 64'(busyOutA), 64'(busyA));
    check("busyB", 64'(busyOutB), 64'(busyB));
    check("stateA", 64'(stateA), 64'(busyA));
  endtask

  // driver: inputs are set just after a rising edge; check at the falling edge, then clock
  task automatic tick();
    @(negedge clk);
    checkOutputs();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic idleInputs();
    weA = 0; weB = 0; clr = 0;
    rdA = '0; rdB = '0; dinA = '0; dinB = '0;
  endtask

  task automatic readAllZero(input string tag);
    weA = 0; weB = 0;
    for (int i = 0; i < NA / 2; i++) begin
      rsA = {AWA'(i + NA / 2), AWA'(i)};
      rsB = {AWB'((i + 4) % NB), AWB'(i % NB)};
      #1;
      check({tag, "_a0"}, 64'(outA[XA-1:0]), 64'd0);
      check({tag, "_a1"}, 64'(outA[2*XA-1:XA]), 64'd0);
      check({tag, "_b0"}, 64'(outB[XB-1:0]), 64'd0);
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < NA; i++) memA[i] = '0;
    for (int i = 0; i < NB; i++) memB[i] = '0;
    idleInputs();
    rsA = '0; rsB = '0;
    rst = 1;
    @(posedge clk);
    modelEdge();
    #1;

    // 1: two reset cycles, sweep, everything reads zero
    tick();
    rst = 0;
    for (int i = 0; i < NA; i++) begin
      rsA = {AWA'($urandom_range(0, NA-1)), AWA'($urandom_range(0, NA-1))};
      weA = 1; rdA = AWA'(i); dinA = $urandom;
      #1;
      check("t1_busy", 64'(busyOutA), 64'd1);
      tick();
    end
    idleInputs();
    #1;
    check("t1_idle", 64'(busyOutA), 64'd0);
    readAllZero("t1_zero");

    // 2: write with bypass, then read back on the other port
    weA = 1; rdA = 5; dinA = 32'hDEADBEEF; rsA = {AWA'(0), AWA'(5)};
    #1;
    check("t2_bypass", 64'(outA[XA-1:0]), 64'hDEADBEEF);
    tick();
    weA = 0; rsA = {AWA'(5), AWA'(0)};
    #1;
    check("t2_read", 64'(outA[2*XA-1:XA]), 64'hDEADBEEF);
    tick();

    // 3: writes to x0 are dropped
    weA = 1; rdA = 0; dinA = 32'h12345678; rsA = '0;
    #1;
    check("t3_same0", 64'(outA[XA-1:0]), 64'd0);
    check("t3_same1", 64'(outA[2*XA-1:XA]), 64'd0);
    tick();
    weA = 0;
    #1;
    check("t3_next", 64'(outA[XA-1:0]), 64'd0);
    tick();

    // 4: no-bypass build returns the pre-write value
    weB = 1; rdB = 7; dinB = 16'h1; tick();
    weB = 1; rdB = 7; dinB = 16'h2; rsB = {AWB'(7), AWB'(7)};
    #1;
    check("t4_old", 64'(outB[XB-1:0]), 64'h1);
    tick();
    weB = 0;
    #1;
    check("t4_new", 64'(outB[XB-1:0]), 64'h2);
    tick();

    // 5: clear request alongside a write, writes ignored during the sweep
    for (int i = 1; i < 6; i++) begin
      weA = 1; rdA = AWA'(i); dinA = $urandom | 32'h1; tick();
    end
    weA = 1; rdA = 3; dinA = 32'hAA; clr = 1; rsA = {AWA'(3), AWA'(4)};
    tick();
    clr = 0;
    for (int i = 0; i < NA; i++) begin
      weA = 1; rdA = AWA'($urandom_range(1, NA-1)); dinA = $urandom;
      #1;
      check("t5_busy", 64'(busyOutA), 64'd1);
      tick();
    end
    idleInputs();
    readAllZero("t5_zero");

    // 6: reset at sweep edge 10 restarts the full count
    clr = 1; tick(); clr = 0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < NA; i++) begin
      #1;
      check("t6_busy", 64'(busyOutA), 64'd1);
      tick();
    end
    #1;
    check("t6_done", 64'(busyOutA), 64'd0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      weA = 1'($urandom_range(0, 1)); rdA = AWA'($urandom_range(0, NA-1)); dinA = $urandom;
      weB = 1'($urandom_range(0, 1)); rdB = AWB'($urandom_range(0, NB-1)); dinB = 16'($urandom);
      rsA = {AWA'($urandom_range(0, NA-1)), AWA'($urandom_range(0, NA-1))};
      if ($urandom_range(0, 3) == 0) rsA[AWA-1:0] = rdA;
      rsB = {AWB'($urandom_range(0, NB-1)), AWB'($urandom_range(0, NB-1))};
      if ($urandom_range(0, 3) == 0) rsB[AWB-1:0] = rdB;
      clr = ($urandom_range(0, 79) == 0);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 0; idleInputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
